mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing a single unified 64-bit memory port between instruction fetch (read-only) and the data stage (load/store). It sits between the core pipeline and the memory/bus interface. Requesters and memory each use a level request / one-cycle ready handshake. The arbiter serialises transactions, registers their payloads, and returns read data to the winning requester.

## Interface
- ADDR_WIDTH, 64, address width (CorePack addr_t)
- DATA_WIDTH, 64, memory data width (CorePack data_t); mask width = DATA_WIDTH/8
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- if_request  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address, 4-byte aligned
- if_ready  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  instruction (inst_t)
- mem_request  in  1  data request, held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  DATA_WIDTH  store data, pre-aligned to byte lanes
- mem_wmask  in  DATA_WIDTH/8  store byte mask
- mem_ready  out  1  one-cycle data completion pulse
- mem_rdata  out  DATA_WIDTH  raw load data (doubleword)
- ram_request  out  1  downstream request
- ram_we, ram_addr, ram_wdata, ram_wmask  out  1/ADDR/DATA/MASK  latched payload
- ram_ready  in  1  downstream completion pulse
- ram_rdata  in  DATA_WIDTH  downstream read data, valid with ram_ready

## Operation
- States: ARB_IDLE, ARB_IF, ARB_MEM, ARB_DONE.
- IDLE: sample requests. Winner per policy (see Configuration). Latch the winner's payload into ram_* and go to ARB_IF or ARB_MEM. For IF, ram_we=0 and ram_wmask=0.
- ARB_IF/ARB_MEM: ram_request=1 with the latched payload, stable. On ram_ready, register ram_rdata, set the matching ready for the next cycle, and go to ARB_DONE.
- ARB_DONE: if_ready or mem_ready =1 for exactly this cycle. ram_request=0. All requests are ignored, so a requester still asserting request in its ready cycle is not reissued. Go to IDLE.
- if_rdata = if_addr_latched[2] ? rdata[63:32] : rdata[31:0].
- mem_rdata = full latched doubleword. The data stage performs extraction.
- For stores, mem_rdata is don't-care but still driven from ram_rdata.
- No pipelining: at most one outstanding downstream transaction.
- Changing requester payload while request is held is illegal. The arbiter uses only the copy latched in IDLE.

## Timing
- Reset (rstn=0 at a clock edge) sets: state=IDLE; ram_request=0, ram_we=0, ram_addr=0, ram_wdata=0, ram_wmask=0; if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0; last_grant=IF.
- Reset mid-transaction abandons it: no ready pulse is issued, and the downstream must tolerate request drop.
- Latency: request sampled in IDLE at cycle 0; ram_request high cycle 1; ram_ready at cycle k≥1; ready high at cycle k+1. The minimum request-to-ready time is 2 cycles.
- Back-to-back: IDLE→grant→DONE→IDLE. The minimum issue interval is 3 cycles per transaction (ram_ready in first grant cycle).
- Simultaneous requests in IDLE: resolved by policy. The loser stays pending, with no loss, and is served after the next DONE.
- ram_ready while IDLE or DONE is ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflict.
  - Grant the requester opposite to last_grant; last_grant updates on every grant.
  - Reset value IF means data wins the first conflict.
- Undefined: fixed priority, data over fetch. last_grant is not implemented.
- Single requester: granted immediately in both modes.

## Structure
- CorePack additions:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_MEM, ARB_DONE} arb_state_enum
  - typedef enum logic {GRANT_IF, GRANT_MEM} arb_grant_enum
- Reuse addr_t, data_t, mask_t, inst_t.
- No sub-module. Grant selection is a small always_comb in mem_arbiter.

## Test plan
- Single fetch: if_request=1, if_addr=0x1004, ram_ready 1 cycle after ram_request, ram_rdata=0xAAAA_BBBB_CCCC_DDDD → ram_addr=0x1004, ram_we=0; if_ready pulse 1 cycle, 2 cycles after ram_ready rise... exact: if_ready the cycle after ram_ready; if_rdata=0xAAAA_BBBB.
- Store: mem_we=1, mem_addr=0x2000, mem_wdata=0x11, mem_wmask=0x01 → ram_* carry these values; mem_ready pulses once; no if_ready.
- Conflict: both requests high in IDLE, ram_ready immediate.
  - Without MEM_ARB_RR_EN: mem served first; fetch served next; mem_ready then if_ready, 3 cycles apart.
  - With MEM_ARB_RR_EN, three consecutive conflicts: order MEM, IF, MEM.
- Held request: requester keeps if_request=1 during the if_ready cycle, then drops it → exactly one ram transaction.
- Reset mid-op: rstn=0 while in ARB_MEM with ram_ready never given → next cycle ram_request=0, mem_ready never pulses, and all outputs are 0.
- Slow memory: ram_ready delayed 10 cycles → ram_request and payload stable for all 10 cycles; no ready until the cycle after ram_ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: bus widths, payload types,
// FSM states and grant encoding, plus the fetch-word lane selector.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int INST_WIDTH = 32;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [MASK_WIDTH-1:0] mask_t;
  typedef logic [INST_WIDTH-1:0] inst_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_MEM, ARB_DONE} arb_state_enum;
  typedef enum logic {GRANT_IF, GRANT_MEM} arb_grant_enum;

  // Address bit 2 picks the upper or lower 32-bit word of the doubleword.
  function automatic inst_t pick_inst(input data_t dw, input logic hi);
    return hi ? dw[DATA_WIDTH-1:INST_WIDTH] : dw[INST_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and downstream RAM handshakes around mem_arbiter.
// slave = arbiter view, master = surrounding core/memory view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic  if_request;
  addr_t if_addr;
  logic  if_ready;
  inst_t if_rdata;

  logic  mem_request;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  mask_t mem_wmask;
  logic  mem_ready;
  data_t mem_rdata;

  logic  ram_request;
  logic  ram_we;
  addr_t ram_addr;
  data_t ram_wdata;
  mask_t ram_wmask;
  logic  ram_ready;
  data_t ram_rdata;

  modport slave (
    input  if_request, if_addr,
    input  mem_request, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  ram_ready, ram_rdata,
    output if_ready, if_rdata,
    output mem_ready, mem_rdata,
    output ram_request, ram_we, ram_addr, ram_wdata, ram_wmask
  );

  modport master (
    output if_request, if_addr,
    output mem_request, mem_we, mem_addr, mem_wdata, mem_wmask,
    output ram_ready, ram_rdata,
    input  if_ready, if_rdata,
    input  mem_ready, mem_rdata,
    input  ram_request, ram_we, ram_addr, ram_wdata, ram_wmask
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, data) onto one 64-bit memory port, one
// transaction at a time. Define MEM_ARB_RR_EN for round-robin on conflict.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  mem_arbiter_if.slave bus
);

  arb_state_enum state_q;
  arb_grant_enum grant_d;
  logic          grant_vld_d;

  logic  ram_request_q;
  logic  ram_we_q;
  addr_t ram_addr_q;
  data_t ram_wdata_q;
  mask_t ram_wmask_q;
  logic  if_ready_q;
  logic  mem_ready_q;
  data_t rdata_q;

`ifdef MEM_ARB_RR_EN
  arb_grant_enum last_grant_q;
`endif

  always_comb begin
    grant_vld_d = bus.if_request | bus.mem_request;
    grant_d     = GRANT_IF;
    if (bus.if_request && bus.mem_request) begin
`ifdef MEM_ARB_RR_EN
      grant_d = (last_grant_q == GRANT_IF) ? GRANT_MEM : GRANT_IF;
`else
      grant_d = GRANT_MEM;
`endif
    end else if (bus.mem_request) begin
      grant_d = GRANT_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ARB_IDLE;
      ram_request_q <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_wmask_q   <= '0;
      if_ready_q    <= 1'b0;
      mem_ready_q   <= 1'b0;
      rdata_q       <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q  <= GRANT_IF;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_vld_d) begin
            ram_request_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_grant_q  <= grant_d;
`endif
            if (grant_d == GRANT_MEM) begin
              ram_we_q    <= bus.mem_we;
              ram_addr_q  <= bus.mem_addr;
              ram_wdata_q <= bus.mem_wdata;
              ram_wmask_q <= bus.mem_wmask;
              state_q     <= ARB_MEM;
            end else begin
              ram_we_q    <= 1'b0;
              ram_addr_q  <= bus.if_addr;
              ram_wdata_q <= '0;
              ram_wmask_q <= '0;
              state_q     <= ARB_IF;
            end
          end
        end
        ARB_IF, ARB_MEM: begin
          // Payload stays frozen until the downstream completes.
          if (bus.ram_ready) begin
            ram_request_q <= 1'b0;
            rdata_q       <= bus.ram_rdata;
            if_ready_q    <= (state_q == ARB_IF);
            mem_ready_q   <= (state_q == ARB_MEM);
            state_q       <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          // Requests still held during the ready pulse are not re-granted.
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          state_q     <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ram_request = ram_request_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_wmask   = ram_wmask_q;
  assign bus.if_ready    = if_ready_q;
  assign bus.mem_ready   = mem_ready_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.if_rdata    = pick_inst(rdata_q, ram_addr_q[2]);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic  is_mem;
    logic  we;
    addr_t addr;
    data_t wdata;
    mask_t wmask;
    int    delay;
    data_t rdata;
    logic  exp_we;
    mask_t exp_mask;
    data_t exp_rd;
  } vec_t;

  vec_t vecs[6];
  int   cf_n;
  int   cf_who[3];
  int   cf_at[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_request  = 1'b0;
    bus.if_addr     = '0;
    bus.mem_request = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_wmask   = '0;
    bus.ram_ready   = 1'b0;
    bus.ram_rdata   = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rreq"},   bus.ram_request, 0);
    chk({tag, "_rwe"},    bus.ram_we,      0);
    chk({tag, "_raddr"},  bus.ram_addr,    0);
    chk({tag, "_rwdata"}, bus.ram_wdata,   0);
    chk({tag, "_rwmask"}, bus.ram_wmask,   0);
    chk({tag, "_ifrdy"},  bus.if_ready,    0);
    chk({tag, "_memrdy"}, bus.mem_ready,   0);
    chk({tag, "_ifrd"},   bus.if_rdata,    0);
    chk({tag, "_memrd"},  bus.mem_rdata,   0);
  endtask

  task automatic do_single(input vec_t v, input int idx);
    string tag;
    bit    stable;
    tag    = $sformatf("v%0d", idx);
    stable = 1'b1;
    if (v.is_mem) begin
      bus.mem_request = 1'b1;   bus.mem_we    = v.we;
      bus.mem_addr    = v.addr; bus.mem_wdata = v.wdata;
      bus.mem_wmask   = v.wmask;
      bus.if_request  = 1'b0;   bus.if_addr   = 64'h5a5a_5a5a_0000_0ff0;
    end else begin
      bus.if_request  = 1'b1;   bus.if_addr   = v.addr;
      bus.mem_request = 1'b0;   bus.mem_we    = 1'b1;
      bus.mem_addr    = '1;     bus.mem_wdata = '1;
      bus.mem_wmask   = '1;
    end
    bus.ram_ready = 1'b0;
    bus.ram_rdata = v.rdata;
    tick();
    chk({tag, "_rreq"},  bus.ram_request, 1);
    chk({tag, "_raddr"}, bus.ram_addr,    v.addr);
    chk({tag, "_rwe"},   bus.ram_we,      v.exp_we);
    chk({tag, "_rmask"}, bus.ram_wmask,   v.exp_mask);
    if (v.is_mem) chk({tag, "_rwdata"}, bus.ram_wdata, v.wdata);
    for (int w = 0; w <= v.delay; w++) begin
      if (!(bus.ram_request === 1'b1 && bus.ram_addr === v.addr &&
            bus.ram_we === v.exp_we && bus.ram_wmask === v.exp_mask &&
            bus.if_ready === 1'b0 && bus.mem_ready === 1'b0)) stable = 1'b0;
      bus.ram_ready = (w == v.delay);
      tick();
    end
    chk({tag, "_stable"}, stable, 1);
    chk({tag, "_ifrdy"},  bus.if_ready,    !v.is_mem);
    chk({tag, "_memrdy"}, bus.mem_ready,   v.is_mem);
    chk({tag, "_rreq_done"}, bus.ram_request, 0);
    if (v.is_mem) chk({tag, "_memrd"}, bus.mem_rdata, v.exp_rd);
    else          chk({tag, "_ifrd"},  bus.if_rdata,  v.exp_rd);
    // Request still held and a stray ram_ready during the ready cycle.
    bus.ram_ready = 1'b1;
    tick();
    chk({tag, "_pulse1"}, bus.if_ready | bus.mem_ready, 0);
    bus.if_request  = 1'b0;
    bus.mem_request = 1'b0;
    tick();
    chk({tag, "_noreissue"}, bus.ram_request, 0);
    chk({tag, "_idle_rdy"},  bus.if_ready | bus.mem_ready, 0);
    bus.ram_ready = 1'b0;
  endtask

  task automatic conflict_run(input bit rereq, input int want);
    cf_n = 0;
    for (int i = 0; i < 3; i++) begin cf_who[i] = -1; cf_at[i] = -1; end
    bus.if_request  = 1'b1; bus.if_addr  = 64'h1008;
    bus.mem_request = 1'b1; bus.mem_addr = 64'h2010; bus.mem_we = 1'b0;
    bus.ram_rdata   = 64'h1111_2222_3333_4444;
    bus.ram_ready   = 1'b0;
    for (int c = 1; c <= 40 && cf_n < want; c++) begin
      tick();
      if (bus.mem_ready) begin
        cf_who[cf_n] = 1; cf_at[cf_n] = c; cf_n++;
        if (!rereq) bus.mem_request = 1'b0;
      end else if (bus.if_ready) begin
        cf_who[cf_n] = 0; cf_at[cf_n] = c; cf_n++;
        if (!rereq) bus.if_request = 1'b0;
      end
      bus.ram_ready = bus.ram_request;
    end
    bus.if_request  = 1'b0;
    bus.mem_request = 1'b0;
    bus.ram_ready   = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic random_run(input int ncyc);
    bit    m_busy, m_rreq, m_win, m_last, m_we;
    addr_t m_addr;
    data_t m_wdata, m_rd;
    mask_t m_mask;
    int    m_due, m_free;
    bit    if_pend, mem_pend, rseen;
    int    rwait, rdelay;
    logic [31:0] exp_inst;
    m_busy = 0; m_rreq = 0; m_win = 0; m_last = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rd = '0; m_mask = '0;
    m_due = -1; m_free = 0;
    if_pend = 0; mem_pend = 0; rseen = 0; rwait = 0; rdelay = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      chk("rnd_rreq", bus.ram_request, m_rreq);
      if (m_rreq) begin
        chk("rnd_raddr", bus.ram_addr,  m_addr);
        chk("rnd_rwe",   bus.ram_we,    m_we);
        chk("rnd_rmask", bus.ram_wmask, m_mask);
        if (m_win) chk("rnd_rwdata", bus.ram_wdata, m_wdata);
      end
      chk("rnd_ifrdy",  bus.if_ready,  (m_due == c) && !m_win);
      chk("rnd_memrdy", bus.mem_ready, (m_due == c) && m_win);
      if (m_due == c) begin
        exp_inst = m_addr[2] ? m_rd[63:32] : m_rd[31:0];
        if (m_win) chk("rnd_memrd", bus.mem_rdata, m_rd);
        else       chk("rnd_ifrd",  bus.if_rdata,  exp_inst);
      end
      // Requesters: hold through the ready cycle, then maybe issue anew.
      if (bus.if_ready) if_pend = 0;
      else if (!if_pend) begin
        if ($urandom_range(2) == 0) begin
          if_pend = 1; bus.if_request = 1'b1;
          bus.if_addr = {$urandom, $urandom} & ~64'h3;
        end else bus.if_request = 1'b0;
      end
      if (bus.mem_ready) mem_pend = 0;
      else if (!mem_pend) begin
        if ($urandom_range(2) == 0) begin
          mem_pend = 1; bus.mem_request = 1'b1;
          bus.mem_we    = $urandom_range(1);
          bus.mem_addr  = {$urandom, $urandom};
          bus.mem_wdata = {$urandom, $urandom};
          bus.mem_wmask = $urandom_range(255);
        end else bus.mem_request = 1'b0;
      end
      // Memory responder with random latency and stray ready pulses.
      if (bus.ram_request) begin
        if (!rseen) begin
          rseen = 1; rwait = 0;
          rdelay = ($urandom_range(7) == 0) ? 10 : $urandom_range(2);
        end
        bus.ram_ready = (rwait == rdelay);
        rwait++;
      end else begin
        rseen = 0;
        bus.ram_ready = ($urandom_range(3) == 0);
      end
      bus.ram_rdata = {$urandom, $urandom};
      // Reference: one transaction at a time, sampled only when free.
      if (!m_busy) begin
        if (c >= m_free && (bus.if_request || bus.mem_request)) begin
          if (bus.if_request && bus.mem_request) m_win = RR ? !m_last : 1'b1;
          else m_win = bus.mem_request;
          m_last = m_win; m_busy = 1; m_rreq = 1;
          if (m_win) begin
            m_addr = bus.mem_addr; m_we = bus.mem_we;
            m_wdata = bus.mem_wdata; m_mask = bus.mem_wmask;
          end else begin
            m_addr = bus.if_addr; m_we = 1'b0; m_mask = '0;
          end
        end
      end else if (bus.ram_ready) begin
        m_busy = 0; m_rreq = 0;
        m_due = c + 1; m_free = c + 2;
        m_rd = bus.ram_rdata;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();

    vecs[0] = '{1'b0, 1'b0, 64'h1004, 64'h0, 8'h00, 0, 64'hAAAA_BBBB_CCCC_DDDD,
                1'b0, 8'h00, 64'h0000_0000_AAAA_BBBB};
    vecs[1] = '{1'b0, 1'b0, 64'h1000, 64'h0, 8'h00, 0, 64'hAAAA_BBBB_CCCC_DDDD,
                1'b0, 8'h00, 64'h0000_0000_CCCC_DDDD};
    vecs[2] = '{1'b1, 1'b1, 64'h2000, 64'h11, 8'h01, 0, 64'h5555_6666_7777_8888,
                1'b1, 8'h01, 64'h5555_6666_7777_8888};
    vecs[3] = '{1'b1, 1'b0, 64'h3008, 64'h0, 8'h00, 2, 64'h0123_4567_89AB_CDEF,
                1'b0, 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1'b0, 1'b0, 64'h100C, 64'h0, 8'h00, 10, 64'hDEAD_BEEF_FEED_FACE,
                1'b0, 8'h00, 64'h0000_0000_DEAD_BEEF};
    vecs[5] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1,
                64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F};

    do_reset();
    check_zero("rst");

    for (int i = 0; i < 6; i++) do_single(vecs[i], i);

    // Reset while a store waits on a downstream that never answers.
    bus.mem_request = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 64'h4000;
    bus.mem_wdata = 64'hFACE; bus.mem_wmask = 8'h0F; bus.ram_ready = 1'b0;
    tick();
    chk("midrst_rreq", bus.ram_request, 1);
    tick(); tick();
    rstn = 1'b0;
    bus.mem_request = 1'b0;
    tick();
    check_zero("midrst");
    rstn = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        bus.ram_ready = i[0];
        tick();
        if (bus.mem_ready !== 1'b0 || bus.ram_request !== 1'b0) seen = 1'b1;
      end
      chk("midrst_quiet", seen, 0);
      bus.ram_ready = 1'b0;
    end

    // Single conflict: data first, fetch after, ready pulses 3 cycles apart.
    do_reset();
    conflict_run(1'b0, 2);
    chk("cf_count", cf_n, 2);
    chk("cf_first", cf_who[0], 1);
    chk("cf_first_at", cf_at[0], 2);
    chk("cf_second", cf_who[1], 0);
    chk("cf_gap", cf_at[1] - cf_at[0], 3);

    // Three back-to-back conflicts with both requesters re-requesting.
    do_reset();
    conflict_run(1'b1, 3);
    chk("cf3_count", cf_n, 3);
    chk("cf3_0", cf_who[0], 1);
    chk("cf3_1", cf_who[1], RR ? 0 : 1);
    chk("cf3_2", cf_who[2], 1);
    chk("cf3_gap", cf_at[2] - cf_at[1], 3);

    do_reset();
    random_run(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
